// File: rtl/ex_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative mul/div.
// A multi-cycle op holds the upstream stages via a combinational stall and
// feeds bubbles into EX/MEM until its result is ready.
module ex_stage_mc #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] rs_1,
  input  logic [DATA_W-1:0] rs_2,
  input  logic [1:0]        frwd_op1_sel,
  input  logic [1:0]        frwd_op2_sel,
  input  logic [1:0]        frwd_store_sel,
  input  logic [DATA_W-1:0] frwd_res_ex,
  input  logic [DATA_W-1:0] frwd_res_mem,
  input  logic [DATA_W-1:0] id_ex_store_data,
  input  logic [REG_AW-1:0] id_ex_op_dest,
  input  logic              id_ex_mem_write_en,
  input  logic              id_ex_wb_mux,
  input  logic              id_ex_wb_en,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_op_dest,
  output logic              ex_mem_write_en,
  output logic              ex_wb_mux,
  output logic              ex_wb_en
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // acc: product high half (mul) or partial remainder (div), one spare bit
  logic [DATA_W:0]   acc_q, acc_d;
  // lo: multiplier shifting out / product low half, or dividend / quotient
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [1:0]        mcmd_q, mcmd_d;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              mw_q, mw_d, mux_q, mux_d, wb_q, wb_d;

  logic [DATA_W-1:0] op1, op2, store_val, sc_res, mc_res;
  logic [DATA_W:0]   mul_sum, div_sh, div_diff;
  logic              is_mc;

  function automatic logic [DATA_W-1:0] fwd(input logic [1:0] sel,
                                            input logic [DATA_W-1:0] base,
                                            input logic [DATA_W-1:0] ex_v,
                                            input logic [DATA_W-1:0] mem_v);
    if (sel == 2'b10)      return ex_v;
    else if (sel == 2'b11) return mem_v;
    else                   return base;
  endfunction

  assign op1       = fwd(frwd_op1_sel, rs_1, frwd_res_ex, frwd_res_mem);
  assign op2       = fwd(frwd_op2_sel, rs_2, frwd_res_ex, frwd_res_mem);
  assign store_val = fwd(frwd_store_sel, id_ex_store_data, frwd_res_ex, frwd_res_mem);
  assign is_mc     = (cmd[3:2] == 2'b10);

  // Hold upstream while a mul/div is launching or iterating; flush and reset release it at once.
  assign stall = !rst && !flush &&
                 (((state_q == IDLE) && in_valid && is_mc) || (state_q == BUSY));

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  assign mul_sum  = {1'b0, acc_q[DATA_W-1:0]} + (lo_q[0] ? {1'b0, opb_q} : '0);
  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
  assign div_sh   = {acc_q[DATA_W-1:0], lo_q[DATA_W-1]};
  assign div_diff = div_sh - {1'b0, opb_q};
  // MULLO/DIVU come from lo, MULHI/REMU from acc.
  assign mc_res   = mcmd_q[0] ? acc_q[DATA_W-1:0] : lo_q;

  // Single-cycle ALU.
  always_comb begin
    sc_res = '0;
    case (cmd)
      4'd0: sc_res = op1 + op2;
      4'd1: sc_res = op1 - op2;
      4'd2: sc_res = op1 & op2;
      4'd3: sc_res = op1 | op2;
      4'd4: sc_res = op1 ^ op2;
      4'd5: sc_res = op1 << op2[SH_W-1:0];
      4'd6: sc_res = op1 >> op2[SH_W-1:0];
      4'd7: sc_res = DATA_W'($signed(op1) >>> op2[SH_W-1:0]);
      default: sc_res = '0;
    endcase
  end

  // Next-state for the FSM, the iterative datapath and the EX/MEM register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    mcmd_d  = mcmd_q;
    res_d   = res_q;
    store_d = store_q;
    dest_d  = dest_q;
    mux_d   = mux_q;
    // Bubble unless a branch below registers a real instruction.
    valid_d = 1'b0;
    mw_d    = 1'b0;
    wb_d    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && is_mc) begin
            acc_d   = '0;
            lo_d    = op1;
            opb_d   = op2;
            mcmd_d  = cmd[1:0];
            cnt_d   = '0;
            state_d = BUSY;
          end else if (in_valid) begin
            valid_d = 1'b1;
            res_d   = sc_res;
            store_d = store_val;
            dest_d  = id_ex_op_dest;
            mw_d    = id_ex_mem_write_en;
            mux_d   = id_ex_wb_mux;
            wb_d    = id_ex_wb_en;
          end
        end
        BUSY: begin
          if (!mcmd_q[1]) begin
            acc_d = {1'b0, mul_sum[DATA_W:1]};
            lo_d  = {mul_sum[0], lo_q[DATA_W-1:1]};
          end else if (div_sh >= {1'b0, opb_q}) begin
            acc_d = div_diff;
            lo_d  = {lo_q[DATA_W-2:0], 1'b1};
          end else begin
            acc_d = div_sh;
            lo_d  = {lo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
        end
        DONE: begin
          valid_d = 1'b1;
          res_d   = mc_res;
          store_d = store_val;
          dest_d  = id_ex_op_dest;
          mw_d    = id_ex_mem_write_en;
          mux_d   = id_ex_wb_mux;
          wb_d    = id_ex_wb_en;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      mcmd_q  <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      store_q <= '0;
      dest_q  <= '0;
      mw_q    <= 1'b0;
      mux_q   <= 1'b0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      mcmd_q  <= mcmd_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      store_q <= store_d;
      dest_q  <= dest_d;
      mw_q    <= mw_d;
      mux_q   <= mux_d;
      wb_q    <= wb_d;
    end
  end

  assign ex_valid        = valid_q;
  assign alu_res         = res_q;
  assign ex_store_data   = store_q;
  assign ex_op_dest      = dest_q;
  assign ex_mem_write_en = mw_q;
  assign ex_wb_mux       = mux_q;
  assign ex_wb_en        = wb_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: a cycle-level expectation model driven by the
// stimulus sequence, checked every negedge, plus literal spot checks.
module tb_ex_stage_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  cmd = '0;
  logic [15:0] rs_1 = '0, rs_2 = '0;
  logic [1:0]  frwd_op1_sel = '0, frwd_op2_sel = '0, frwd_store_sel = '0;
  logic [15:0] frwd_res_ex = '0, frwd_res_mem = '0, id_ex_store_data = '0;
  logic [2:0]  id_ex_op_dest = '0;
  logic        id_ex_mem_write_en = 1'b0, id_ex_wb_mux = 1'b0, id_ex_wb_en = 1'b0;
  logic        stall, ex_valid, ex_mem_write_en, ex_wb_mux, ex_wb_en;
  logic [15:0] alu_res, ex_store_data;
  logic [2:0]  ex_op_dest;

  ex_stage_mc #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .cmd(cmd),
    .rs_1(rs_1), .rs_2(rs_2),
    .frwd_op1_sel(frwd_op1_sel), .frwd_op2_sel(frwd_op2_sel), .frwd_store_sel(frwd_store_sel),
    .frwd_res_ex(frwd_res_ex), .frwd_res_mem(frwd_res_mem),
    .id_ex_store_data(id_ex_store_data), .id_ex_op_dest(id_ex_op_dest),
    .id_ex_mem_write_en(id_ex_mem_write_en), .id_ex_wb_mux(id_ex_wb_mux), .id_ex_wb_en(id_ex_wb_en),
    .stall(stall), .ex_valid(ex_valid), .alu_res(alu_res), .ex_store_data(ex_store_data),
    .ex_op_dest(ex_op_dest), .ex_mem_write_en(ex_mem_write_en), .ex_wb_mux(ex_wb_mux),
    .ex_wb_en(ex_wb_en)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b1;

  // Expected DUT outputs, maintained by the stimulus process.
  logic        exp_stall = 1'b0, exp_valid = 1'b0, exp_mw = 1'b0, exp_mux = 1'b0, exp_wb = 1'b0;
  logic [15:0] exp_res = '0, exp_store = '0;
  logic [2:0]  exp_dest = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the expectation model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("ex_valid", 32'(ex_valid), 32'(exp_valid));
      chk("alu_res", 32'(alu_res), 32'(exp_res));
      chk("ex_store_data", 32'(ex_store_data), 32'(exp_store));
      chk("ex_op_dest", 32'(ex_op_dest), 32'(exp_dest));
      chk("ex_mem_write_en", 32'(ex_mem_write_en), 32'(exp_mw));
      chk("ex_wb_mux", 32'(ex_wb_mux), 32'(exp_mux));
      chk("ex_wb_en", 32'(ex_wb_en), 32'(exp_wb));
    end
  end

  function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] base,
                                       input logic [15:0] ex_v, input logic [15:0] mem_v);
    if (sel == 2'b10) return ex_v;
    if (sel == 2'b11) return mem_v;
    return base;
  endfunction

  // Result from the arithmetic definition of each command.
  function automatic logic [15:0] model_res(input logic [3:0] c, input logic [15:0] a,
                                            input logic [15:0] b);
    int unsigned ua = a, ub = b, p = ua * ub, sh = ub % 16;
    int sa = int'($signed(a));
    case (c)
      4'd0:  return 16'(ua + ub);
      4'd1:  return 16'(ua - ub);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return 16'(ua << sh);
      4'd6:  return 16'(ua >> sh);
      4'd7:  return 16'(sa >>> sh);
      4'd8:  return p[15:0];
      4'd9:  return p[31:16];
      4'd10: return (ub == 0) ? 16'hFFFF : 16'(ua / ub);
      4'd11: return (ub == 0) ? a : 16'(ua % ub);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_bubble();
    exp_valid = 1'b0;
    exp_mw = 1'b0;
    exp_wb = 1'b0;
  endtask

  task automatic present(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] ss,
                         input logic [15:0] fex, input logic [15:0] fmem, input logic [15:0] sd,
                         input logic [2:0] dest, input logic mw, input logic mux, input logic wb);
    in_valid = 1'b1; cmd = c; rs_1 = a; rs_2 = b;
    frwd_op1_sel = s1; frwd_op2_sel = s2; frwd_store_sel = ss;
    frwd_res_ex = fex; frwd_res_mem = fmem; id_ex_store_data = sd;
    id_ex_op_dest = dest; id_ex_mem_write_en = mw; id_ex_wb_mux = mux; id_ex_wb_en = wb;
    exp_stall = (c >= 4'd8) && (c <= 4'd11);
  endtask

  // Issue one instruction, follow it to EX/MEM, then drop in_valid for one bubble cycle.
  task automatic run_op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] ss,
                        input logic [15:0] fex, input logic [15:0] fmem, input logic [15:0] sd,
                        input logic [2:0] dest, input logic mw, input logic mux, input logic wb,
                        output logic [15:0] got, output int stall_cycles);
    logic [15:0] o1, o2;
    o1 = pick(s1, a, fex, fmem);
    o2 = pick(s2, b, fex, fmem);
    present(c, a, b, s1, s2, ss, fex, fmem, sd, dest, mw, mux, wb);
    #1;
    stall_cycles = 0;
    if (c >= 4'd8 && c <= 4'd11) begin
      for (int k = 0; k < 17; k++) begin
        if (stall) stall_cycles++;
        tick();
        exp_bubble();
        exp_stall = (k < 16);
      end
      if (stall) stall_cycles++;
    end
    tick();
    exp_valid = 1'b1;
    exp_res   = model_res(c, o1, o2);
    exp_store = pick(ss, sd, fex, fmem);
    exp_dest  = dest; exp_mw = mw; exp_mux = mux; exp_wb = wb;
    got = alu_res;
    in_valid = 1'b0;
    exp_stall = 1'b0;
    $display("op cmd=%0d a=%0h b=%0h -> alu_res=%0h ex_valid=%0b stall_cycles=%0d",
             c, o1, o2, alu_res, ex_valid, stall_cycles);
    tick();
    exp_bubble();
  endtask

  logic [15:0] got;
  int sc;

  initial begin
    // Reset state.
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Model pins against hand-computed values.
    chk("model_mulhi", 32'(model_res(4'd9, 16'hFFFF, 16'hFFFF)), 32'h0000_FFFE);
    chk("model_divu0", 32'(model_res(4'd10, 16'd9, 16'd0)), 32'h0000_FFFF);
    chk("model_sra", 32'(model_res(4'd7, 16'h8000, 16'd3)), 32'h0000_F000);

    // ADD overflow wrap.
    run_op(4'd0, 16'h7FFF, 16'h0001, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h1234,
           3'd5, 1'b1, 1'b0, 1'b1, got, sc);
    chk("t1_add", 32'(got), 32'h8000);
    chk("t1_stall_cycles", 32'(sc), 32'd0);

    // SUB with both operands forwarded, store forwarded from EX.
    run_op(4'd1, 16'd99, 16'd77, 2'b10, 2'b11, 2'b10, 16'd20, 16'd5, 16'hAAAA,
           3'd2, 1'b0, 1'b1, 1'b1, got, sc);
    chk("t2_sub", 32'(got), 32'd15);
    chk("t2_store", 32'(ex_store_data), 32'd20);

    // A few more single-cycle patterns, including sel=01 meaning register value.
    run_op(4'd5, 16'h0001, 16'h0014, 2'b01, 2'b00, 2'b11, 16'h0, 16'h5555, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1, got, sc);
    chk("sll", 32'(got), 32'h0010);
    run_op(4'd7, 16'h8000, 16'h0003, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h7, 3'd3, 1'b1, 1'b1, 1'b0, got, sc);
    chk("sra", 32'(got), 32'hF000);
    run_op(4'd6, 16'h8000, 16'h0003, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h7, 3'd4, 1'b0, 1'b0, 1'b1, got, sc);
    chk("srl", 32'(got), 32'h1000);
    run_op(4'd4, 16'hF0F0, 16'h0FF0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 3'd6, 1'b0, 1'b0, 1'b1, got, sc);
    run_op(4'd13, 16'h1234, 16'h5678, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 3'd7, 1'b0, 1'b1, 1'b1, got, sc);
    chk("cmd13_zero", 32'(got), 32'h0);

    // Multi-cycle ops.
    run_op(4'd9, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0BAD, 3'd3, 1'b1, 1'b0, 1'b1, got, sc);
    chk("t3_mulhi", 32'(got), 32'hFFFE);
    chk("t3_stall_cycles", 32'(sc), 32'd17);
    run_op(4'd8, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 3'd4, 1'b0, 1'b1, 1'b1, got, sc);
    chk("t3_mullo", 32'(got), 32'h0001);
    run_op(4'd10, 16'd100, 16'd7, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1, got, sc);
    chk("t4_divu", 32'(got), 32'd14);
    run_op(4'd11, 16'd100, 16'd7, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 3'd1, 1'b0, 1'b0, 1'b1, got, sc);
    chk("t4_remu", 32'(got), 32'd2);
    run_op(4'd10, 16'd9, 16'd0, 2'b00, 2'b00, 2'b10, 16'h0042, 16'h0, 16'h0, 3'd2, 1'b0, 1'b1, 1'b1, got, sc);
    chk("t4_divu0", 32'(got), 32'hFFFF);
    chk("t4_divu0_stall", 32'(sc), 32'd17);
    run_op(4'd11, 16'd9, 16'd0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 3'd2, 1'b0, 1'b0, 1'b1, got, sc);
    chk("t4_remu0", 32'(got), 32'd9);
    // Forwarded operands latched at launch.
    run_op(4'd8, 16'd0, 16'd0, 2'b11, 2'b10, 2'b00, 16'd300, 16'd200, 16'h0, 3'd5, 1'b1, 1'b0, 1'b0, got, sc);
    chk("mullo_fwd", 32'(got), 32'hEA60);

    // Flush during BUSY cycle 5.
    present(4'd10, 16'd100, 16'd7, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 3'd6, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_bubble();
    end
    flush = 1'b1;
    exp_stall = 1'b0;
    #1;
    chk("t5_stall_drop", 32'(stall), 32'd0);
    tick();
    exp_bubble();
    flush = 1'b0;
    $display("flush issued during DIVU busy cycle 5");
    run_op(4'd0, 16'd2, 16'd3, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1, got, sc);
    chk("t5_add", 32'(got), 32'd5);
    chk("t5_add_stall", 32'(sc), 32'd0);

    // Asynchronous reset during BUSY.
    present(4'd10, 16'd100, 16'd7, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 3'd6, 1'b1, 1'b1, 1'b1);
    repeat (3) begin
      tick();
      exp_bubble();
    end
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_stall = 1'b0; exp_valid = 1'b0; exp_res = '0; exp_store = '0;
    exp_dest = '0; exp_mw = 1'b0; exp_mux = 1'b0; exp_wb = 1'b0;
    #1;
    chk("t6_rst_res", 32'(alu_res), 32'h0);
    chk("t6_rst_dest", 32'(ex_op_dest), 32'h0);
    chk("t6_rst_stall", 32'(stall), 32'h0);
    $display("reset asserted during DIVU busy");
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_op(4'd8, 16'd3, 16'd4, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 3'd2, 1'b0, 1'b0, 1'b1, got, sc);
    chk("t6_mullo", 32'(got), 32'd12);

    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
